serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor_cell.sv | 22 ++
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master issues operands, slave returns results.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full-subtractor cell: Diff = A - B - Bin, Borr set when the bit position must borrow.
module full_subtractor_behi_ifelse (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Borr
);

  always_comb begin
    Diff = A ^ B ^ Bin;
    // Equal bits pass the incoming borrow through; otherwise B alone decides.
    if (A == B) begin
      Borr = Bin;
    end else if (B) begin
      Borr = 1'b1;
    end else begin
      Borr = 1'b0;
    end
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b over WIDTH cycles, LSB first, through one cell.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one operand bit pair per cycle through the cell, borrow fed back
// DONE  | done pulse; diff/borrow_out freshly loaded
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic             cell_diff;
  logic             cell_borr;

  full_subtractor_behi_ifelse u_cell (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (borrow_q),
    .Diff (cell_diff),
    .Borr (cell_borr)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bo_d     = bo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // res holds the lower WIDTH-1 result bits; the final bit comes straight from the cell.
        res_d    = (WIDTH-1)'({cell_diff, res_q} >> 1);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_borr;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {cell_diff, res_q};
          bo_d    = cell_borr;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bo_q     <= bo_d;
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timing/arithmetic model plus directed literal cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int done_cyc_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: an accepted operation is described only by its age in edges since acceptance.
  bit           m_active = 1'b0;
  int           m_since  = 0;
  bit           was_idle;
  logic [W-1:0] m_pend_diff, m_diff;
  logic         m_pend_bo, m_bo;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_since  = 0;
      m_diff   = '0;
      m_bo     = 1'b0;
    end else begin
      was_idle = !m_active;
      if (m_active) begin
        m_since++;
        if (m_since == W) begin
          m_diff = m_pend_diff;
          m_bo   = m_pend_bo;
        end
        if (m_since == W + 1) m_active = 1'b0;
      end
      if (was_idle && bus.start) begin
        m_active    = 1'b1;
        m_since     = 0;
        m_pend_diff = bus.a - bus.b;
        m_pend_bo   = (bus.a < bus.b);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", bus.busy, m_active && (m_since < W));
      check("done", bus.done, m_active && (m_since == W));
      check("diff", bus.diff, m_diff);
      check("borrow_out", bus.borrow_out, m_bo);
      if (bus.done) begin
        n_done++;
        done_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input string nm);
    int budget;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    budget = 0;
    while (!bus.done && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.done) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      check({nm, "_diff"}, bus.diff, ed);
      check({nm, "_bo"}, bus.borrow_out, eb);
      check({nm, "_latency"}, budget, W);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit first_seen;
    int base;
    int nd;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bo", bus.borrow_out, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h35, 8'h12, 8'h23, 1'b0, "basic");

    // Previous result must hold through the next operation's SHIFT cycles.
    bus.a = 8'h12;
    bus.b = 8'h35;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("hold_diff", bus.diff, 8'h23);
      @(negedge clk);
    end
    check("neg_diff", bus.diff, 8'hDD);
    check("neg_bo", bus.borrow_out, 1);
    @(negedge clk);

    run_op(8'h00, 8'h01, 8'hFF, 1'b1, "zero_minus_one");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "max_minus_zero");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, "zero_minus_max");

    // start held high with operands changing every cycle.
    first_seen = 1'b0;
    base = done_cyc_q.size();
    bus.a = 8'h35;
    bus.b = 8'h12;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done && !first_seen) begin
        first_seen = 1'b1;
        check("held_first_diff", bus.diff, 8'h23);
        check("held_first_bo", bus.borrow_out, 0);
      end
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("held_first_seen", first_seen, 1);
    if (done_cyc_q.size() >= base + 2)
      check("held_spacing", done_cyc_q[base+1] - done_cyc_q[base], W + 2);
    else
      check("held_two_dones", done_cyc_q.size() - base, 2);

    // Reset on the 4th SHIFT cycle.
    bus.a = 8'h35;
    bus.b = 8'h12;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_diff", bus.diff, 0);
    check("midrst_bo", bus.borrow_out, 0);
    nd = n_done;
    repeat (12) @(negedge clk);
    check("midrst_no_done", n_done, nd);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, "after_rst");

    // Reset and start on the same edge.
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_vs_start_busy", bus.busy, 0);
    nd = n_done;
    repeat (12) @(negedge clk);
    check("rst_vs_start_no_done", n_done, nd);
    check("rst_vs_start_diff", bus.diff, 0);

    // Randomized traffic; the model decides acceptance and results.
    for (int i = 0; i < 15000; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a = pick_operand();
      bus.b = pick_operand();
      rst = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
